// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared frame layout and receiver state encoding
// Optional parity support is selected by UART_PARITY_EN.
package uart_pkg;

  localparam int FRAME_BITS = 8;
  localparam int BIT_CNT_W  = $clog2(FRAME_BITS);
  localparam int NIBBLE_W   = 4;
  localparam int REG_W      = 2 * NIBBLE_W;
  localparam int ADDR_MSB   = 7;
  localparam int ADDR_LSB   = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_PARITY_EN
    ST_PARITY = 3'd4,
`endif
    ST_STOP   = 3'd3
  } rx_state_t;

  // Register index carried by a frame: the address field without its odd/even bit.
  function automatic logic [2:0] frame_reg_index(input logic [FRAME_BITS-1:0] frame);
    return frame[ADDR_MSB:ADDR_LSB+1];
  endfunction

endpackage

// File: rtl/uart_rx_frame.sv
// rtl/uart_rx_frame.sv - oversampling serial receiver: synchroniser, phase counter, frame FSM
// With UART_PARITY_EN an even-parity bit is checked before the stop bit.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int OSR = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_rx,
  output logic                  o_byte_vld,
  output logic [FRAME_BITS-1:0] o_byte,
  output logic                  o_frame_err,
  output logic                  o_idle,
  output logic                  o_start
);

  localparam int PW = $clog2(OSR);

  logic                  r_rx_m, r_rx_s, r_rx_d;
  rx_state_t             r_state, w_next;
  logic [PW-1:0]         r_phase;
  logic [BIT_CNT_W-1:0]  r_bit_cnt;
  logic [FRAME_BITS-1:0] r_shift;
  logic                  w_sample, w_par_ok;

  // Synchroniser flops reset to the idle level so reset release never looks like a start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_m <= 1'b1;
      r_rx_s <= 1'b1;
      r_rx_d <= 1'b1;
    end else begin
      r_rx_m <= i_rx;
      r_rx_s <= r_rx_m;
      r_rx_d <= r_rx_s;
    end
  end

  assign o_idle   = (r_state == ST_IDLE);
  assign o_start  = o_idle && r_rx_d && !r_rx_s;
  assign w_sample = (r_phase == PW'(OSR / 2));
  assign o_byte   = r_shift;

`ifdef UART_PARITY_EN
  logic r_par_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_par_bit <= 1'b0;
    end else if (r_state == ST_PARITY && w_sample) begin
      r_par_bit <= r_rx_s;
    end
  end

  assign w_par_ok = (r_par_bit == ^r_shift);
`else
  assign w_par_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    o_byte_vld  = 1'b0;
    o_frame_err = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (o_start) w_next = ST_START;
      end
      ST_START: begin
        if (w_sample) w_next = r_rx_s ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (w_sample && r_bit_cnt == BIT_CNT_W'(FRAME_BITS - 1)) begin
`ifdef UART_PARITY_EN
          w_next = ST_PARITY;
`else
          w_next = ST_STOP;
`endif
        end
      end
`ifdef UART_PARITY_EN
      ST_PARITY: begin
        if (w_sample) w_next = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (w_sample) begin
          w_next = ST_IDLE;
          if (r_rx_s && w_par_ok) o_byte_vld  = 1'b1;
          else                    o_frame_err = 1'b1;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Phase is held at zero in IDLE so the first START cycle is count 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase   <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else begin
      if (r_state == ST_IDLE || r_phase == PW'(OSR - 1)) r_phase <= '0;
      else                                              r_phase <= r_phase + 1'b1;

      if (r_state == ST_IDLE) begin
        r_bit_cnt <= '0;
      end else if (r_state == ST_DATA && w_sample) begin
        r_shift   <= {r_rx_s, r_shift[FRAME_BITS-1:1]};
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_reg_decoder.sv
// rtl/uart_reg_decoder.sv - nibble-pair frame decoder, hold/timeout logic and register file
// Build option UART_PARITY_EN enables the even-parity frame format in the receiver.
module uart_reg_decoder
  import uart_pkg::*;
#(
  parameter int OSR          = 5,
  parameter int NUM_REGS     = 8,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rx,
  output logic [REG_W*NUM_REGS-1:0] regs,
  output logic [NUM_REGS-1:0]       wr_stb,
  output logic                      reg_change,
  output logic                      frame_err,
  output logic                      seq_err
);

  localparam int PW    = $clog2(OSR);
  localparam bit TO_EN = (TIMEOUT_BITS > 0);
  localparam int IW    = TO_EN ? $clog2(TIMEOUT_BITS + 1) : 1;

  logic                  w_byte_vld, w_frame_err, w_idle, w_start, w_timeout;
  logic [FRAME_BITS-1:0] w_byte;
  logic [3:0]            w_addr;
  logic [NIBBLE_W-1:0]   w_data;
  logic [2:0]            w_k;
  logic                  w_k_ok;

  logic [REG_W-1:0]      r_regs [NUM_REGS];
  logic [NUM_REGS-1:0]   r_wr_stb;
  logic                  r_reg_change, r_frame_err, r_seq_err;
  logic                  r_hold_vld;
  logic [NIBBLE_W-1:0]   r_hold;
  logic [2:0]            r_hold_k;

  uart_rx_frame #(.OSR(OSR)) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_rx       (rx),
    .o_byte_vld (w_byte_vld),
    .o_byte     (w_byte),
    .o_frame_err(w_frame_err),
    .o_idle     (w_idle),
    .o_start    (w_start)
  );

  assign w_addr = w_byte[ADDR_MSB:ADDR_LSB];
  assign w_data = w_byte[NIBBLE_W-1:0];
  assign w_k    = frame_reg_index(w_byte);
  assign w_k_ok = (int'(w_k) < NUM_REGS);

  // Idle bit-period counter; a start edge in the expiry cycle wins and keeps the hold.
  generate
    if (TO_EN) begin : g_timeout
      logic [PW-1:0] r_pre;
      logic [IW-1:0] r_idle_cnt;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_pre      <= '0;
          r_idle_cnt <= '0;
        end else if (w_start || !w_idle || !r_hold_vld) begin
          r_pre      <= '0;
          r_idle_cnt <= '0;
        end else if (r_pre == PW'(OSR - 1)) begin
          r_pre      <= '0;
          r_idle_cnt <= r_idle_cnt + 1'b1;
        end else begin
          r_pre <= r_pre + 1'b1;
        end
      end

      assign w_timeout = w_idle && r_hold_vld && !w_start &&
                         (r_pre == PW'(OSR - 1)) &&
                         (r_idle_cnt == IW'(TIMEOUT_BITS - 1));
    end else begin : g_no_timeout
      assign w_timeout = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      r_wr_stb     <= '0;
      r_reg_change <= 1'b0;
      r_frame_err  <= 1'b0;
      r_seq_err    <= 1'b0;
      r_hold_vld   <= 1'b0;
      r_hold       <= '0;
      r_hold_k     <= '0;
    end else begin
      r_wr_stb    <= '0;
      r_seq_err   <= 1'b0;
      r_frame_err <= w_frame_err;
      if (w_byte_vld && w_k_ok) begin
        if (!w_addr[0]) begin
          r_hold     <= w_data;
          r_hold_k   <= w_k;
          r_hold_vld <= 1'b1;
        end else begin
          r_hold_vld <= 1'b0;
          if (r_hold_vld && r_hold_k == w_k) begin
            r_regs[w_k]  <= {w_data, r_hold};
            r_wr_stb     <= NUM_REGS'(1) << w_k;
            r_reg_change <= ~r_reg_change;
          end else begin
            r_seq_err <= 1'b1;
          end
        end
      end else if (w_timeout) begin
        r_hold_vld <= 1'b0;
      end
    end
  end

  generate
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
      assign regs[REG_W*g +: REG_W] = r_regs[g];
    end
  endgenerate

  assign wr_stb     = r_wr_stb;
  assign reg_change = r_reg_change;
  assign frame_err  = r_frame_err;
  assign seq_err    = r_seq_err;

endmodule
